// File: rtl/frame_renderer.sv
// 640x480@60 VGA timing plus paddle/ball/block-field renderer with a per-frame shadow of game state.
// Optional build macro BLOCK_GAP_EN: leaves the last column/row of each block cell as background.
module frame_renderer #(
  parameter int PIX_DIV   = 2,
  parameter int PADDLE_Y  = 448,
  parameter int BALL_SIZE = 8,
  parameter int BLK_X0    = 32,
  parameter int BLK_Y0    = 32,
  parameter int BLK_W     = 48,
  parameter int BLK_H     = 16,
  parameter int H_VIS     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VIS     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [9:0]  PADDLE_X_PIXEL,
  input  logic [9:0]  BALL_X_PIXEL,
  input  logic [9:0]  BALL_Y_PIXEL,
  input  logic [71:0] BLOCK_STATE,
  output logic        FRAME_RENDERED,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic [7:0]  RGB
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int BXW   = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int BYW   = (BLK_H > 1) ? $clog2(BLK_H) : 1;

  localparam logic [DW-1:0]  DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [9:0]     H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0]     V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0]     H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0]     V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0]     HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0]     HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]     VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0]     VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0]     V_FR     = 10'(V_VIS - 1);
  localparam logic [9:0]     V_SHD    = 10'(V_TOT - 2);
  localparam logic [9:0]     X0       = 10'(BLK_X0);
  localparam logic [9:0]     Y0       = 10'(BLK_Y0);
  localparam logic [BXW-1:0] BW_LAST  = BXW'(BLK_W - 1);
  localparam logic [BYW-1:0] BH_LAST  = BYW'(BLK_H - 1);
  localparam logic [10:0]    PAD_Y0   = 11'(PADDLE_Y);
  localparam logic [10:0]    PAD_Y1   = 11'(PADDLE_Y + 8);
  localparam logic [10:0]    BALL_SZ  = 11'(BALL_SIZE);

  typedef struct packed {
    logic [9:0]  pad_x;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic [71:0] blk;
  } shadow_t;

  logic [DW-1:0]  div_q, div_d;
  logic [9:0]     h_q, h_d, v_q, v_d, h_nx, v_nx;
  logic [BXW-1:0] bsx_q, bsx_d;
  logic [BYW-1:0] bsy_q, bsy_d;
  logic [3:0]     bcol_q, bcol_d;
  logic [2:0]     brow_q, brow_d;
  logic           bxa_q, bxa_d, bya_q, bya_d;
  shadow_t        sh_q, sh_d;
  logic [7:0]     rgb_q, rgb_d, pix;
  logic           hs_q, hs_d, vs_q, vs_d, fr_q, fr_d;
  logic           tick, eol;

  // Pixel colour for the current counters, using shadow state only.
  logic [10:0] hx, vy;
  logic [6:0]  blk_idx;
  logic        vis, ball_hit, pad_hit, blk_hit, gap;
  logic [7:0]  row_col;

  always_comb begin
    hx       = {1'b0, h_q};
    vy       = {1'b0, v_q};
    vis      = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    ball_hit = (hx >= {1'b0, sh_q.ball_x}) && (hx < {1'b0, sh_q.ball_x} + BALL_SZ) &&
               (vy >= {1'b0, sh_q.ball_y}) && (vy < {1'b0, sh_q.ball_y} + BALL_SZ);
    pad_hit  = (hx >= {1'b0, sh_q.pad_x}) && (hx < {1'b0, sh_q.pad_x} + 11'd64) &&
               (vy >= PAD_Y0) && (vy < PAD_Y1);
    blk_idx  = 7'(brow_q) * 7'd12 + 7'(bcol_q);
`ifdef BLOCK_GAP_EN
    gap      = (bsx_q == BW_LAST) || (bsy_q == BH_LAST);
`else
    gap      = 1'b0;
`endif
    blk_hit  = bxa_q && bya_q && sh_q.blk[blk_idx] && !gap;
    case (brow_q)
      3'd0:    row_col = 8'hE0;
      3'd1:    row_col = 8'hF0;
      3'd2:    row_col = 8'hFC;
      3'd3:    row_col = 8'h1C;
      3'd4:    row_col = 8'h1F;
      3'd5:    row_col = 8'hE3;
      default: row_col = 8'h00;
    endcase
    pix = 8'h00;
    if (vis) begin
      if (ball_hit)     pix = 8'hFC;
      else if (pad_hit) pix = 8'hFF;
      else if (blk_hit) pix = row_col;
    end
  end

  always_comb begin
    tick   = (div_q == DIV_LAST);
    eol    = (h_q == H_LAST);
    h_nx   = eol ? 10'd0 : h_q + 10'd1;
    v_nx   = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    div_d  = tick ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    bsx_d  = bsx_q;
    bcol_d = bcol_q;
    bxa_d  = bxa_q;
    bsy_d  = bsy_q;
    brow_d = brow_q;
    bya_d  = bya_q;
    sh_d   = sh_q;
    rgb_d  = rgb_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    fr_d   = tick && eol && (v_q == V_FR);
    if (tick) begin
      h_d   = h_nx;
      rgb_d = pix;
      hs_d  = !((h_q >= HS_BEG) && (h_q < HS_END));
      vs_d  = !((v_q >= VS_BEG) && (v_q < VS_END));
      // Column tracking follows h_nx so it always describes the counter it sits beside.
      if (h_nx == X0) begin
        bsx_d = '0; bcol_d = 4'd0; bxa_d = 1'b1;
      end else if (h_nx == 10'd0) begin
        bxa_d = 1'b0;
      end else if (bxa_q) begin
        if (bsx_q == BW_LAST) begin
          bsx_d  = '0;
          bcol_d = bcol_q + 4'd1;
          bxa_d  = (bcol_q != 4'd11);
        end else begin
          bsx_d = bsx_q + 1'b1;
        end
      end
      if (eol) begin
        v_d = v_nx;
        if (v_nx == Y0) begin
          bsy_d = '0; brow_d = 3'd0; bya_d = 1'b1;
        end else if (v_nx == 10'd0) begin
          bya_d = 1'b0;
        end else if (bya_q) begin
          if (bsy_q == BH_LAST) begin
            bsy_d  = '0;
            brow_d = brow_q + 3'd1;
            bya_d  = (brow_q != 3'd5);
          end else begin
            bsy_d = bsy_q + 1'b1;
          end
        end
        // Latch game state on entry to the last vblank line.
        if (v_q == V_SHD)
          sh_d = '{pad_x: PADDLE_X_PIXEL, ball_x: BALL_X_PIXEL,
                   ball_y: BALL_Y_PIXEL, blk: BLOCK_STATE};
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      bsx_q  <= '0;
      bcol_q <= '0;
      bxa_q  <= (BLK_X0 == 0);
      bsy_q  <= '0;
      brow_q <= '0;
      bya_q  <= (BLK_Y0 == 0);
      sh_q   <= '0;
      rgb_q  <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      fr_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      bsx_q  <= bsx_d;
      bcol_q <= bcol_d;
      bxa_q  <= bxa_d;
      bsy_q  <= bsy_d;
      brow_q <= brow_d;
      bya_q  <= bya_d;
      sh_q   <= sh_d;
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fr_q   <= fr_d;
    end
  end

  assign RGB            = rgb_q;
  assign HSYNC          = hs_q;
  assign VSYNC          = vs_q;
  assign FRAME_RENDERED = fr_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Directed bench for frame_renderer on a shrunken raster (same porch/sync structure) so
// several frames fit in a short run; expected pixels are hand-computed per vector.
module tb_frame_renderer;
  localparam int HV = 88, HF = 4, HS = 8, HB = 4, HT = HV + HF + HS + HB;
  localparam int VV = 60, VF = 2, VS = 2, VB = 2, VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int PY = 48;
`ifdef BLOCK_GAP_EN
  localparam logic [7:0] GAPC = 8'h00;
`else
  localparam logic [7:0] GAPC = 8'hE0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [9:0]  PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL;
  logic [71:0] BLOCK_STATE;
  logic        FRAME_RENDERED, HSYNC, VSYNC;
  logic [7:0]  RGB;

  frame_renderer #(
    .PIX_DIV(2), .PADDLE_Y(PY), .BALL_SIZE(8), .BLK_X0(32), .BLK_Y0(32), .BLK_W(48), .BLK_H(16),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .PADDLE_X_PIXEL(PADDLE_X_PIXEL), .BALL_X_PIXEL(BALL_X_PIXEL),
    .BALL_Y_PIXEL(BALL_Y_PIXEL), .BLOCK_STATE(BLOCK_STATE), .FRAME_RENDERED(FRAME_RENDERED),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .RGB(RGB)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errs = 0;
  int edge_n = 0;
  int fr_cnt = 0, fr_hi = 0;
  int fr_pos [3];
  logic fr_prev = 1'b0;

  // Clock edges since reset release; edge 2*(p+1) registers linear pixel p.
  always @(posedge CLK or negedge RST_N)
    if (!RST_N) edge_n <= 0;
    else        edge_n <= edge_n + 1;

  always @(negedge CLK) begin
    if (RST_N && FRAME_RENDERED) begin
      fr_hi <= fr_hi + 1;
      if (!fr_prev) begin
        if (fr_cnt < 3) fr_pos[fr_cnt] <= edge_n;
        fr_cnt <= fr_cnt + 1;
      end
    end
    fr_prev <= FRAME_RENDERED;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic at_edge(input int e);
    if (edge_n > e) begin
      errs++;
      $display("FAIL order edge_n=%0d target=%0d", edge_n, e);
    end
    while (edge_n < e) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic int pix_edge(input int f, input int x, input int y);
    return 2 * (f * FT + y * HT + x + 1) + 1;
  endfunction

  typedef struct {
    int f; int x; int y;
    logic [7:0] rgb; logic hs; logic vs;
  } vec_t;
  vec_t tv[$];

  initial begin
    #1_500_000;
    $display("FAIL watchdog edge_n=%0d", edge_n);
    $fatal(1, "timeout");
  end

  initial begin
    int chg_edge, e;
    bit upd_done;
    // Frame 0: shadow still cleared -> paddle at x=0, ball at (0,0), no blocks.
    tv.push_back('{0, 0, 0, 8'hFC, 1, 1});
    tv.push_back('{0, 7, 7, 8'hFC, 1, 1});
    tv.push_back('{0, 8, 7, 8'h00, 1, 1});
    tv.push_back('{0, 7, 8, 8'h00, 1, 1});
    tv.push_back('{0, 40, 36, 8'h00, 1, 1});
    tv.push_back('{0, 0, 48, 8'hFF, 1, 1});
    tv.push_back('{0, 63, 55, 8'hFF, 1, 1});
    tv.push_back('{0, 64, 55, 8'h00, 1, 1});
    tv.push_back('{0, 10, 56, 8'h00, 1, 1});
    tv.push_back('{0, 91, 56, 8'h00, 1, 1});
    tv.push_back('{0, 92, 56, 8'h00, 0, 1});
    tv.push_back('{0, 99, 56, 8'h00, 0, 1});
    tv.push_back('{0, 100, 56, 8'h00, 1, 1});
    tv.push_back('{0, 10, 61, 8'h00, 1, 1});
    tv.push_back('{0, 10, 62, 8'h00, 1, 0});
    tv.push_back('{0, 95, 63, 8'h00, 0, 0});
    tv.push_back('{0, 10, 64, 8'h00, 1, 1});
    // Frame 1: block 0 only, ball/paddle off-screen; inputs change at line 20 must not show.
    tv.push_back('{1, 32, 32, 8'hE0, 1, 1});
    tv.push_back('{1, 31, 40, 8'h00, 1, 1});
    tv.push_back('{1, 40, 40, 8'hE0, 1, 1});
    tv.push_back('{1, 55, 40, 8'hE0, 1, 1});
    tv.push_back('{1, 79, 40, GAPC, 1, 1});
    tv.push_back('{1, 80, 40, 8'h00, 1, 1});
    tv.push_back('{1, 50, 47, GAPC, 1, 1});
    tv.push_back('{1, 32, 48, 8'h00, 1, 1});
    tv.push_back('{1, 0, 50, 8'h00, 1, 1});
    // Frame 2: ball (36,36), paddle x=0, blocks 0,1 (row 0) and 12 (row 1 col 0).
    tv.push_back('{2, 38, 35, 8'hE0, 1, 1});
    tv.push_back('{2, 35, 36, 8'hE0, 1, 1});
    tv.push_back('{2, 36, 36, 8'hFC, 1, 1});
    tv.push_back('{2, 43, 43, 8'hFC, 1, 1});
    tv.push_back('{2, 44, 43, 8'hE0, 1, 1});
    tv.push_back('{2, 79, 43, GAPC, 1, 1});
    tv.push_back('{2, 80, 43, 8'hE0, 1, 1});
    tv.push_back('{2, 87, 43, 8'hE0, 1, 1});
    tv.push_back('{2, 88, 43, 8'h00, 1, 1});
    tv.push_back('{2, 43, 44, 8'hE0, 1, 1});
    tv.push_back('{2, 40, 47, GAPC, 1, 1});
    tv.push_back('{2, 0, 48, 8'hFF, 1, 1});
    tv.push_back('{2, 63, 50, 8'hFF, 1, 1});
    tv.push_back('{2, 64, 50, 8'hF0, 1, 1});
    tv.push_back('{2, 70, 50, 8'hF0, 1, 1});
    tv.push_back('{2, 85, 50, 8'h00, 1, 1});
    tv.push_back('{2, 31, 56, 8'h00, 1, 1});
    tv.push_back('{2, 40, 56, 8'hF0, 1, 1});
    tv.push_back('{2, 40, 59, 8'hF0, 1, 1});
    tv.push_back('{2, 40, 60, 8'h00, 1, 1});

    RST_N = 1'b0;
    PADDLE_X_PIXEL = 10'd1000;
    BALL_X_PIXEL   = 10'd1000;
    BALL_Y_PIXEL   = 10'd1000;
    BLOCK_STATE    = 72'h1;
    repeat (3) @(negedge CLK);
    chk("reset rgb", 32'(RGB), 32'h00);
    chk("reset hsync", 32'(HSYNC), 32'h1);
    chk("reset vsync", 32'(VSYNC), 32'h1);
    chk("reset frame_rendered", 32'(FRAME_RENDERED), 32'h0);
    RST_N = 1'b1;

    chg_edge = pix_edge(1, 0, 20);
    upd_done = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      e = pix_edge(tv[i].f, tv[i].x, tv[i].y);
      if (!upd_done && e > chg_edge) begin
        at_edge(chg_edge);
        PADDLE_X_PIXEL = 10'd0;
        BALL_X_PIXEL   = 10'd36;
        BALL_Y_PIXEL   = 10'd36;
        BLOCK_STATE    = 72'h1003;
        upd_done = 1'b1;
      end
      at_edge(e);
      chk($sformatf("f%0d(%0d,%0d) rgb", tv[i].f, tv[i].x, tv[i].y), 32'(RGB), 32'(tv[i].rgb));
      chk($sformatf("f%0d(%0d,%0d) hsync", tv[i].f, tv[i].x, tv[i].y), 32'(HSYNC), 32'(tv[i].hs));
      chk($sformatf("f%0d(%0d,%0d) vsync", tv[i].f, tv[i].x, tv[i].y), 32'(VSYNC), 32'(tv[i].vs));
    end

    // Strobe count, width and placement over frames 0..2.
    chk("fr pulse count", 32'(fr_cnt), 32'd3);
    chk("fr high cycles", 32'(fr_hi), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("fr%0d edge", i), 32'(fr_pos[i]), 32'(2 * (VV * HT + i * FT)));

    // Reset in the middle of frame 3 while the ball is being drawn.
    at_edge(pix_edge(3, 40, 36));
    chk("pre-reset ball", 32'(RGB), 32'hFC);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid reset rgb", 32'(RGB), 32'h00);
    chk("mid reset hsync", 32'(HSYNC), 32'h1);
    chk("mid reset vsync", 32'(VSYNC), 32'h1);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    at_edge(pix_edge(0, 0, 0));
    chk("post-reset shadow ball", 32'(RGB), 32'hFC);
    at_edge(pix_edge(0, 40, 36));
    chk("post-reset shadow blocks", 32'(RGB), 32'h00);
    e = 2 * VV * HT;
    at_edge(e - 1);
    chk("post-reset fr before", 32'(FRAME_RENDERED), 32'h0);
    at_edge(e);
    chk("post-reset fr at", 32'(FRAME_RENDERED), 32'h1);
    at_edge(e + 1);
    chk("post-reset fr after", 32'(FRAME_RENDERED), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end
endmodule
